// File: rtl/traffic_monitor.sv
// traffic_monitor: independent checker on the four-approach lamp bus.
// Flags illegal aspects, out-of-order phases and dwell-time violations, latching the first fault.
module traffic_monitor #(
  parameter int DWELL_L = 7,
  parameter int DWELL_R = 6,
  parameter int DWELL_S = 5,
  parameter int DWELL_B = 7,
  parameter int TOL     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [2:0]  l,
  input  logic [2:0]  r,
  input  logic [2:0]  s,
  input  logic [2:0]  b,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [1:0]  phase,
  output logic        phase_valid,
  output logic        in_sync,
  output logic [15:0] cycles
);

  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] AMB = 3'b010;
  localparam logic [2:0] RED = 3'b100;

  typedef enum logic [1:0] {ST_SYNC, ST_TRACK, ST_FAULT} state_t;

  state_t     state;
  logic [2:0] l_q, r_q, s_q, b_q;
  logic       tick_q;
  logic       armed;
  logic       seen;
  logic [3:0] dwell;

  logic [3:0] greens;
  logic       codes_ok, multi_green, aspect_ok, valid, change;
  logic [1:0] dec_phase;
  logic [2:0] pat_code, track_code, new_code;
  int         dwell_exp, credited;

  function automatic logic is_code(input logic [2:0] c);
    return (c == GRN) || (c == AMB) || (c == RED);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      l_q    <= '0;
      r_q    <= '0;
      s_q    <= '0;
      b_q    <= '0;
      tick_q <= 1'b0;
    end else begin
      l_q    <= l;
      r_q    <= r;
      s_q    <= s;
      b_q    <= b;
      tick_q <= tick;
    end
  end

  always_comb begin
    greens      = {b_q == GRN, s_q == GRN, r_q == GRN, l_q == GRN};
    codes_ok    = is_code(l_q) && is_code(r_q) && is_code(s_q) && is_code(b_q);
    multi_green = (greens & (greens - 4'd1)) != 4'd0;
    dec_phase   = 2'd0;
    aspect_ok   = 1'b0;
    case (greens)
      4'b0001: begin dec_phase = 2'd0; aspect_ok = (r_q == AMB) && (s_q == RED) && (b_q == RED); end
      4'b0010: begin dec_phase = 2'd1; aspect_ok = (l_q == RED) && (s_q == AMB) && (b_q == RED); end
      4'b0100: begin dec_phase = 2'd2; aspect_ok = (l_q == RED) && (r_q == RED) && (b_q == AMB); end
      4'b1000: begin dec_phase = 2'd3; aspect_ok = (l_q == AMB) && (r_q == RED) && (s_q == RED); end
      default: ;
    endcase

    if (!codes_ok)            pat_code = 3'd1;
    else if (multi_green)     pat_code = 3'd2;
    else if (greens == 4'd0)  pat_code = 3'd3;
    else if (!aspect_ok)      pat_code = 3'd4;
    else                      pat_code = 3'd0;
    valid = (pat_code == 3'd0);

    case (phase)
      2'd0:    dwell_exp = DWELL_L;
      2'd1:    dwell_exp = DWELL_R;
      2'd2:    dwell_exp = DWELL_S;
      default: dwell_exp = DWELL_B;
    endcase
    // A tick arriving with the phase change still belongs to the outgoing phase.
    credited = int'(dwell) + int'(tick_q);
    change   = valid && seen && (dec_phase != phase);

    track_code = 3'd0;
    if (change && (dec_phase != 2'(phase + 2'd1)))
      track_code = 3'd5;
    else if (change && (credited < dwell_exp - TOL))
      track_code = 3'd6;
    else if (valid && !change && tick_q && (int'(dwell) + 1 > dwell_exp + TOL))
      track_code = 3'd7;

    if (pat_code != 3'd0)       new_code = pat_code;
    else if (state == ST_TRACK) new_code = track_code;
    else                        new_code = 3'd0;
  end

  // The first sample after reset holds the cleared input stage, so it is skipped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_SYNC;
      armed       <= 1'b0;
      seen        <= 1'b0;
      dwell       <= 4'd0;
      fault       <= 1'b0;
      fault_code  <= 3'd0;
      phase       <= 2'd0;
      phase_valid <= 1'b0;
      in_sync     <= 1'b0;
      cycles      <= 16'd0;
    end else begin
      armed <= 1'b1;
      if (armed) begin
        phase_valid <= valid;
        if (valid) begin
          phase <= dec_phase;
          seen  <= 1'b1;
        end
        case (state)
          ST_SYNC, ST_TRACK: begin
            if (new_code != 3'd0) begin
              state      <= ST_FAULT;
              fault      <= 1'b1;
              fault_code <= new_code;
              in_sync    <= 1'b0;
            end else if (change) begin
              dwell   <= 4'd0;
              state   <= ST_TRACK;
              in_sync <= 1'b1;
              if (state == ST_TRACK && phase == 2'd3 && cycles != 16'hFFFF)
                cycles <= cycles + 16'd1;
            end else if (tick_q && dwell != 4'hF) begin
              dwell <= dwell + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_traffic_monitor.sv
// tb_traffic_monitor: directed and randomized lamp-bus traffic checked against
// a phase-level behavioural model every cycle, plus literal expectations.
module tb_traffic_monitor;

  localparam int DL  = 7;
  localparam int DR  = 6;
  localparam int DS  = 5;
  localparam int DB  = 7;
  localparam int TOL = 1;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] AMB = 3'b010;
  localparam logic [2:0] RED = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [2:0]  l, r, s, b;
  logic        fault;
  logic [2:0]  fault_code;
  logic [1:0]  phase;
  logic        phase_valid;
  logic        in_sync;
  logic [15:0] cycles;

  int checks_total  = 0;
  int checks_passed = 0;

  bit m_fault, m_valid, m_have, m_track;
  int m_code, m_phase, m_dwell, m_cycles;

  logic [3:0][2:0] stim;

  traffic_monitor #(
    .DWELL_L(DL), .DWELL_R(DR), .DWELL_S(DS), .DWELL_B(DB), .TOL(TOL)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .l(l), .r(r), .s(s), .b(b),
    .fault(fault), .fault_code(fault_code), .phase(phase),
    .phase_valid(phase_valid), .in_sync(in_sync), .cycles(cycles)
  );

  always #5 clk = ~clk;

  function automatic int dwell_of(input int p);
    case (p)
      0:       return DL;
      1:       return DR;
      2:       return DS;
      default: return DB;
    endcase
  endfunction

  // Approach index 0..3 = l, r, s, b; the next phase's approach shows amber.
  function automatic logic [2:0] aspect(input int p, input int a);
    if (a == p) return GRN;
    if (a == (p + 1) % 4) return AMB;
    return RED;
  endfunction

  function automatic logic [3:0][2:0] lamps_of(input int p);
    logic [3:0][2:0] v;
    for (int i = 0; i < 4; i++) v[i] = aspect(p, i);
    return v;
  endfunction

  function automatic int pattern_code(input logic [3:0][2:0] lamp, output int green);
    int ng;
    bit bad;
    ng = 0;
    bad = 0;
    green = 0;
    for (int i = 0; i < 4; i++) begin
      if (!(lamp[i] == GRN || lamp[i] == AMB || lamp[i] == RED)) bad = 1;
      if (lamp[i] == GRN) begin ng++; green = i; end
    end
    if (bad) return 1;
    if (ng > 1) return 2;
    if (ng == 0) return 3;
    for (int i = 0; i < 4; i++)
      if (lamp[i] != aspect(green, i)) return 4;
    return 0;
  endfunction

  task automatic model_reset();
    m_fault = 0; m_valid = 0; m_have = 0; m_track = 0;
    m_code = 0; m_phase = 0; m_dwell = 0; m_cycles = 0;
  endtask

  task automatic model_step(input logic [3:0][2:0] lamp, input bit t);
    int g, pat, code, credited;
    bit change;
    pat  = pattern_code(lamp, g);
    code = pat;
    if (!m_fault) begin
      change   = (pat == 0) && m_have && (g != m_phase);
      credited = m_dwell + (t ? 1 : 0);
      if (pat == 0 && m_track) begin
        if (change && g != (m_phase + 1) % 4) code = 5;
        else if (change && credited < dwell_of(m_phase) - TOL) code = 6;
        else if (!change && t && m_dwell + 1 > dwell_of(m_phase) + TOL) code = 7;
      end
      if (code != 0) begin
        m_fault = 1;
        m_code  = code;
      end else if (change) begin
        if (m_track && m_phase == 3 && m_cycles < 65535) m_cycles++;
        m_track = 1;
        m_dwell = 0;
      end else if (t && m_dwell < 15) begin
        m_dwell++;
      end
    end
    m_valid = (pat == 0);
    if (pat == 0) begin
      m_phase = g;
      m_have  = 1;
    end
  endtask

  // Outputs after edge k reflect the lamp sample taken at edge k-1.
  task automatic monitor_loop();
    logic [3:0][2:0] prev_lamp;
    bit prev_tick, prev_rst, started;
    logic [23:0] act, exp;
    prev_rst = 1;
    started  = 0;
    prev_tick = 0;
    prev_lamp = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        model_reset();
        started = 1;
      end else if (!prev_rst) begin
        model_step(prev_lamp, prev_tick);
      end
      prev_rst  = rst;
      prev_lamp = {b, s, r, l};
      prev_tick = tick;
      #1;
      if (started) begin
        act = {fault, fault_code, phase, phase_valid, in_sync, cycles};
        exp = {m_fault, 3'(m_code), 2'(m_phase), m_valid, m_track && !m_fault, 16'(m_cycles)};
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("[TB] FAIL outputs t=%0t got f=%0b code=%0d ph=%0d pv=%0b sync=%0b cyc=%0d, expected f=%0b code=%0d ph=%0d pv=%0b sync=%0b cyc=%0d",
                      $time, act[23], act[22:20], act[19:18], act[17], act[16], act[15:0],
                      exp[23], exp[22:20], exp[19:18], exp[17], exp[16], exp[15:0]);
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [3:0][2:0] lamp, input logic t);
    {b, s, r, l} = lamp;
    tick = t;
    @(negedge clk);
  endtask

  task automatic hold_phase(input int p, input int nticks, input int gap, input bit lead);
    if (lead) applyStimulus(lamps_of(p), 1'b1);
    for (int k = 0; k < nticks; k++) begin
      for (int g = 1; g < gap; g++) applyStimulus(lamps_of(p), 1'b0);
      applyStimulus(lamps_of(p), 1'b1);
    end
    applyStimulus(lamps_of(p), 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) applyStimulus(lamps_of(0), 1'b0);
    rst = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, " fault"}, 16'(fault), 16'd0);
    checkOutput({tag, " fault_code"}, 16'(fault_code), 16'd0);
    checkOutput({tag, " phase"}, 16'(phase), 16'd0);
    checkOutput({tag, " phase_valid"}, 16'(phase_valid), 16'd0);
    checkOutput({tag, " in_sync"}, 16'(in_sync), 16'd0);
    checkOutput({tag, " cycles"}, cycles, 16'd0);
  endtask

  initial begin
    int p, np, d, roll;
    rst = 1'b1;
    tick = 1'b0;
    {b, s, r, l} = lamps_of(0);
    fork
      monitor_loop();
    join_none

    do_reset(2);
    check_reset_values("reset");

    $display("[TB] legal run, three rounds");
    hold_phase(0, 3, 2, 0);
    checkOutput("sync before change", 16'(in_sync), 16'd0);
    hold_phase(1, DR, 2, 0);
    checkOutput("in_sync after left->right", 16'(in_sync), 16'd1);
    hold_phase(2, DS, 2, 0);
    hold_phase(3, DB, 2, 0);
    for (int k = 0; k < 2; k++) begin
      hold_phase(0, DL, 2, 0);
      hold_phase(1, DR, 2, 0);
      hold_phase(2, DS, 2, 0);
      hold_phase(3, DB, 2, 0);
    end
    hold_phase(0, DL, 2, 0);
    checkOutput("legal run fault", 16'(fault), 16'd0);
    checkOutput("legal run cycles", cycles, 16'd3);
    checkOutput("legal run in_sync", 16'(in_sync), 16'd1);

    $display("[TB] illegal lamp code");
    stim = lamps_of(0);
    stim[0] = 3'b011;
    applyStimulus(stim, 1'b0);
    checkOutput("code1 not before latency", 16'(fault), 16'd0);
    applyStimulus(lamps_of(0), 1'b0);
    checkOutput("code1 fault", 16'(fault), 16'd1);
    checkOutput("code1 value", 16'(fault_code), 16'd1);
    hold_phase(1, DR, 2, 0);
    hold_phase(2, DS, 2, 0);
    hold_phase(3, DB, 2, 0);
    hold_phase(0, DL, 2, 0);
    checkOutput("code1 frozen", 16'(fault_code), 16'd1);
    checkOutput("cycles frozen", cycles, 16'd3);

    $display("[TB] double green in sync");
    do_reset(1);
    hold_phase(0, 2, 2, 0);
    stim = lamps_of(0);
    stim[1] = GRN;
    applyStimulus(stim, 1'b0);
    stim[1] = AMB;
    stim[2] = 3'b000;
    applyStimulus(stim, 1'b0);
    applyStimulus(lamps_of(0), 1'b0);
    checkOutput("code2 value", 16'(fault_code), 16'd2);
    checkOutput("code2 in_sync", 16'(in_sync), 16'd0);

    $display("[TB] short right phase");
    do_reset(1);
    hold_phase(0, 2, 2, 0);
    hold_phase(1, 3, 2, 0);
    applyStimulus(lamps_of(2), 1'b0);
    checkOutput("code6 not before latency", 16'(fault), 16'd0);
    applyStimulus(lamps_of(2), 1'b0);
    checkOutput("code6 value", 16'(fault_code), 16'd6);

    $display("[TB] long straight phase");
    do_reset(1);
    hold_phase(0, 2, 2, 0);
    hold_phase(1, DR, 2, 0);
    for (int k = 0; k < 7; k++) begin
      applyStimulus(lamps_of(2), 1'b0);
      applyStimulus(lamps_of(2), 1'b1);
    end
    checkOutput("code7 not before latency", 16'(fault), 16'd0);
    applyStimulus(lamps_of(2), 1'b0);
    checkOutput("code7 value", 16'(fault_code), 16'd7);

    $display("[TB] skipped phase then reset");
    do_reset(1);
    hold_phase(0, 2, 2, 0);
    hold_phase(1, DR, 2, 0);
    hold_phase(2, DS, 2, 0);
    hold_phase(3, DB, 2, 0);
    hold_phase(0, DL, 2, 0);
    applyStimulus(lamps_of(2), 1'b0);
    applyStimulus(lamps_of(2), 1'b0);
    checkOutput("code5 value", 16'(fault_code), 16'd5);
    rst = 1'b1;
    applyStimulus(lamps_of(2), 1'b0);
    check_reset_values("after fault reset");
    rst = 1'b0;
    hold_phase(0, 3, 2, 0);
    hold_phase(1, DR, 2, 0);
    checkOutput("resync in_sync", 16'(in_sync), 16'd1);
    checkOutput("resync fault", 16'(fault), 16'd0);

    $display("[TB] randomized runs");
    for (int it = 0; it < 8; it++) begin
      do_reset(1 + $urandom_range(0, 1));
      p = 0;
      hold_phase(0, $urandom_range(0, 4), 1 + $urandom_range(0, 2), 0);
      for (int st = 0; st < 12; st++) begin
        roll = $urandom_range(0, 99);
        if (roll < 4) begin
          stim = lamps_of(p);
          stim[$urandom_range(0, 3)] = 3'($urandom_range(0, 7));
          applyStimulus(stim, 1'($urandom_range(0, 1)));
        end
        np = (roll >= 4 && roll < 9) ? int'($urandom_range(0, 3)) : (p + 1) % 4;
        if (roll >= 90) d = dwell_of(np) + int'($urandom_range(0, 4)) - 2;
        else            d = dwell_of(np) + int'($urandom_range(0, 2)) - 1;
        if (d < 0) d = 0;
        hold_phase(np, d, 1 + $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        p = np;
      end
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
